// File: rtl/CPU_package.sv
// Shared CPU definitions: datapath width and the ALU opcode encoding used by
// the Logic unit and every front end that drives it.
// No ports; consumed by logic_issue_ctrl and its interface.
package CPU_package;

  localparam int DATA_WIDTH = 8;

  // AND/OR/XOR/NOT/CPR are the Logic unit's operations; ADD/SUB belong to the
  // arithmetic unit and are reported as errors if they reach this controller.
  typedef enum logic [2:0] {
    ALU_OP_AND = 3'd0,
    ALU_OP_OR  = 3'd1,
    ALU_OP_XOR = 3'd2,
    ALU_OP_NOT = 3'd3,
    ALU_OP_CPR = 3'd4,
    ALU_OP_ADD = 3'd5,
    ALU_OP_SUB = 3'd6
  } enum_alu_opcode_t;

endpackage

// File: rtl/logic_issue_ctrl_if.sv
// Instruction and response channels between decode and the logic issue controller.
// Instruction channel: instr_valid/instr_ready plus op, rd, ra, rb.
// Response channel: rsp_valid/rsp_ready plus data, flag and error.
interface logic_issue_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int REG_AW     = 2
);
  import CPU_package::*;

  logic                  instr_valid;
  logic                  instr_ready;
  enum_alu_opcode_t      instr_op;
  logic [REG_AW-1:0]     instr_rd;
  logic [REG_AW-1:0]     instr_ra;
  logic [REG_AW-1:0]     instr_rb;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic [2:0]            rsp_flag;
  logic                  rsp_err;

  // Decode side.
  modport master (
    output instr_valid, instr_op, instr_rd, instr_ra, instr_rb, rsp_ready,
    input  instr_ready, rsp_valid, rsp_data, rsp_flag, rsp_err
  );

  // Controller side.
  modport slave (
    input  instr_valid, instr_op, instr_rd, instr_ra, instr_rb, rsp_ready,
    output instr_ready, rsp_valid, rsp_data, rsp_flag, rsp_err
  );

endinterface

// File: rtl/logic_issue_ctrl.sv
// Sequential front end for the Logic unit: accepts an instruction, reads two
// operands from a small local register file, drives the Logic unit, captures
// the result or compare flags, writes back and returns a response.
// Ports: clk/rst; bus (slave modport: instruction and response handshakes);
// ld_* register preload; alu_a/alu_b/alu_opcode out to the Logic unit;
// alu_result/alu_flag back from it; flag_eq/gt/lt of the last CPR; busy.
module logic_issue_ctrl
  import CPU_package::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REGS   = 4,
  parameter int REG_AW     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  logic_issue_ctrl_if.slave     bus,
  input  logic                  ld_en,
  input  logic [REG_AW-1:0]     ld_addr,
  input  logic [DATA_WIDTH-1:0] ld_data,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  output enum_alu_opcode_t      alu_opcode,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic [2:0]            alu_flag,
  output logic                  flag_eq,
  output logic                  flag_gt,
  output logic                  flag_lt,
  output logic                  busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_WB,
    S_RESP
  } state_t;

  state_t                state;
  logic [REG_AW-1:0]     rd_q;
  logic [DATA_WIDTH-1:0] rf [NUM_REGS];

  logic                  rsp_valid_q;
  logic [DATA_WIDTH-1:0] rsp_data_q;
  logic [2:0]            rsp_flag_q;
  logic                  rsp_err_q;

  assign bus.instr_ready = (state == S_IDLE);
  assign busy            = (state != S_IDLE);
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_data    = rsp_data_q;
  assign bus.rsp_flag    = rsp_flag_q;
  assign bus.rsp_err     = rsp_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      rd_q        <= '0;
      for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_opcode  <= ALU_OP_AND;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_flag_q  <= 3'b000;
      rsp_err_q   <= 1'b0;
      flag_eq     <= 1'b0;
      flag_gt     <= 1'b0;
      flag_lt     <= 1'b0;
    end else begin
      // Preload first so that a writeback to the same address in this
      // cycle, assigned later in the block, takes precedence.
      if (ld_en) rf[ld_addr] <= ld_data;

      case (state)
        S_IDLE: begin
          if (bus.instr_valid) begin
            // Operand read uses pre-edge contents; no forwarding from ld_*.
            rd_q       <= bus.instr_rd;
            alu_a      <= rf[bus.instr_ra];
            alu_b      <= rf[bus.instr_rb];
            alu_opcode <= bus.instr_op;
            state      <= S_EXEC;
          end
        end

        // ALU inputs stay put for a full cycle so the Logic unit settles.
        S_EXEC: state <= S_WB;

        S_WB: begin
          rsp_valid_q <= 1'b1;
          rsp_data_q  <= '0;
          rsp_flag_q  <= 3'b000;
          rsp_err_q   <= 1'b0;
          state       <= S_RESP;
          case (alu_opcode)
            ALU_OP_AND, ALU_OP_OR, ALU_OP_XOR, ALU_OP_NOT: begin
              rf[rd_q]   <= alu_result;
              rsp_data_q <= alu_result;
            end
            ALU_OP_CPR: begin
              rsp_flag_q <= alu_flag;
              flag_eq    <= alu_flag[2];
              flag_gt    <= alu_flag[1];
              flag_lt    <= alu_flag[0];
            end
            default: rsp_err_q <= 1'b1;
          endcase
        end

        S_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state       <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
